// File: rtl/word_bus_arbiter_pkg.sv
// rtl/word_bus_arbiter_pkg.sv - shared types and constants for the word bus arbiter
//
// Holds the arbiter state encoding and the bus geometry used by the top level
// and by the data-select mux.

package word_bus_arbiter_pkg;

    // Number of requesters sharing the bus and the width of one bus word.
    localparam int NUM_REQ = 4;
    localparam int WORD_W  = 32;

    // Width of a requester index and of the BUSY-cycle counter.
    localparam int ID_W  = 2;
    localparam int CNT_W = 8;

    // Arbiter state encoding: IDLE = 0, BUSY = 1.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage : word_bus_arbiter_pkg

// File: rtl/four_word_mux.sv
// rtl/four_word_mux.sv - four-input word selector for the shared bus
//
// Ports:
//   sel        - binary index of the word to forward
//   d0..d3     - candidate words
//   y          - selected word (purely combinational)

module four_word_mux
    import word_bus_arbiter_pkg::*;
(
    input  logic [ID_W-1:0]   sel,
    input  logic [WORD_W-1:0] d0,
    input  logic [WORD_W-1:0] d1,
    input  logic [WORD_W-1:0] d2,
    input  logic [WORD_W-1:0] d3,
    output logic [WORD_W-1:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = d0;
        endcase
    end

endmodule : four_word_mux

// File: rtl/word_bus_arbiter.sv
// rtl/word_bus_arbiter.sv - four-requester round-robin arbiter for a shared word bus
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous, active-high
//   req        - per-requester level request, held until its transfer ends
//   data0..3   - per-requester write words
//   ack        - single-cycle completion pulse from the bus target
//   grant      - registered one-hot grant
//   gnt_id     - registered binary index of the granted requester (holds in IDLE)
//   bus_valid  - high while a grant is active
//   bus_data   - word of the granted requester, 0 when no grant is active
//   timeout    - one-cycle pulse after a forced release
//
// Parameter:
//   TIMEOUT    - BUSY cycles without ack before the grant is forcibly released (1..255)

module word_bus_arbiter
    import word_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [WORD_W-1:0]    data0,
    input  logic [WORD_W-1:0]    data1,
    input  logic [WORD_W-1:0]    data2,
    input  logic [WORD_W-1:0]    data3,
    input  logic                 ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic [ID_W-1:0]      gnt_id,
    output logic                 bus_valid,
    output logic [WORD_W-1:0]    bus_data,
    output logic                 timeout
);

    // The counter holds the number of completed BUSY cycles; release is
    // forced at the edge that ends the TIMEOUT-th BUSY cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t           state_q,   state_d;
    logic [NUM_REQ-1:0]   grant_q,   grant_d;
    logic [ID_W-1:0]      gnt_id_q,  gnt_id_d;
    logic [ID_W-1:0]      ptr_q,     ptr_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic                 timeout_q, timeout_d;

    logic [ID_W-1:0]      pick_id;
    logic [WORD_W-1:0]    mux_word;

    // Round-robin search: first set request bit at or above ptr, wrapping
    // modulo 4. Scanning offsets from highest to lowest lets the smallest
    // offset overwrite the result last.
    always_comb begin
        pick_id = ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[ptr_q + ID_W'(k)]) begin
                pick_id = ptr_q + ID_W'(k);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Any release lands here for at least one cycle, so a new
                // grant can never follow a release back-to-back.
                if (|req) begin
                    state_d  = BUSY;
                    grant_d  = NUM_REQ'(1) << pick_id;
                    gnt_id_d = pick_id;
                    cnt_d    = '0;
                end
            end

            BUSY: begin
                // Ack outranks both an abort and an expiring counter; an abort
                // never produces a timeout pulse.
                if (ack || !req[gnt_id_q] || (cnt_q == CNT_LAST)) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    ptr_d     = gnt_id_q + ID_W'(1);
                    cnt_d     = '0;
                    timeout_d = !ack && req[gnt_id_q];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    four_word_mux u_mux (
        .sel (gnt_id_q),
        .d0  (data0),
        .d1  (data1),
        .d2  (data2),
        .d3  (data3),
        .y   (mux_word)
    );

    // bus_valid follows the registered state, so an asynchronous reset
    // clears it and bus_data without waiting for a clock edge.
    assign bus_valid = (state_q == BUSY);
    assign bus_data  = bus_valid ? mux_word : '0;
    assign grant     = grant_q;
    assign gnt_id    = gnt_id_q;
    assign timeout   = timeout_q;

endmodule : word_bus_arbiter

// File: tb/tb_word_bus_arbiter.sv
// tb/tb_word_bus_arbiter.sv - self-checking bench for word_bus_arbiter

module tb_word_bus_arbiter;

    localparam int TMO = 3;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data0, data1, data2, data3;
    logic        ack;
    logic [3:0]  grant;
    logic [1:0]  gnt_id;
    logic        bus_valid;
    logic [31:0] bus_data;
    logic        timeout;

    int n_cmp;
    int n_bad;

    word_bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .ack       (ack),
        .grant     (grant),
        .gnt_id    (gnt_id),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [3:0] req;
        logic       ack;
        logic [3:0] grant;
        logic [1:0] id;
        logic       valid;
        logic       tmo;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] tdata[4];

    task automatic add(input logic [3:0] r, input logic a, input logic [3:0] g,
                       input logic [1:0] i, input logic v, input logic t);
        vec_t e;
        e.req = r; e.ack = a; e.grant = g; e.id = i; e.valid = v; e.tmo = t;
        tbl.push_back(e);
    endtask

    // ---------------- reference model ----------------
    // Arbiter described as "who owns the bus, how long they have held it,
    // and where the next search starts".
    bit          m_busy;
    int          m_owner;
    int          m_ptr;
    int          m_held;
    bit          m_tpulse;
    logic [31:0] m_data[4];

    task automatic m_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_tpulse = 0;
    endtask

    task automatic m_step(input logic [3:0] r, input logic a);
        bit rel;
        bit tp;
        bit found;
        rel = 0; tp = 0; found = 0;
        if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                if (!found && r[(m_ptr + k) % 4]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % 4;
                end
            end
            if (found) begin
                m_busy = 1;
                m_held = 0;
            end
        end else begin
            m_held++;
            if (a)                rel = 1;
            else if (!r[m_owner]) rel = 1;
            else if (m_held >= TMO) begin
                rel = 1;
                tp  = 1;
            end
            if (rel) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % 4;
            end
        end
        m_tpulse = tp;
    endtask

    task automatic m_compare(input string tag);
        chk({tag, ".grant"},     {28'd0, grant},     m_busy ? (32'd1 << m_owner) : 32'd0);
        chk({tag, ".gnt_id"},    {30'd0, gnt_id},    32'(m_owner));
        chk({tag, ".bus_valid"}, {31'd0, bus_valid}, {31'd0, m_busy});
        chk({tag, ".bus_data"},  bus_data,           m_busy ? m_data[m_owner] : 32'd0);
        chk({tag, ".timeout"},   {31'd0, timeout},   {31'd0, m_tpulse});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tdata[0] = 32'hAAAA0000;
        tdata[1] = 32'h11111111;
        tdata[2] = 32'h22222222;
        tdata[3] = 32'h33333333;
        reset = 1'b1; req = 4'b0; ack = 1'b0;
        data0 = tdata[0]; data1 = tdata[1]; data2 = tdata[2]; data3 = tdata[3];

        // Each row: inputs held during one cycle and the outputs expected in
        // that same cycle (before the edge that consumes the inputs).
        //   req      ack   grant    id   v  t
        add(4'b0101, 1'b0, 4'b0000, 2'd0, 0, 0); // idle, request pending
        add(4'b0101, 1'b1, 4'b0001, 2'd0, 1, 0); // req0 granted, ack
        add(4'b0101, 1'b0, 4'b0000, 2'd0, 0, 0); // mandatory idle
        add(4'b0101, 1'b1, 4'b0100, 2'd2, 1, 0); // search from 1 finds 2
        add(4'b0000, 1'b0, 4'b0000, 2'd2, 0, 0); // idle, gnt_id holds
        add(4'b0000, 1'b1, 4'b0000, 2'd2, 0, 0); // ack in IDLE ignored
        add(4'b0010, 1'b0, 4'b0000, 2'd2, 0, 0); // timeout case
        add(4'b0010, 1'b0, 4'b0010, 2'd1, 1, 0); // busy 1
        add(4'b0010, 1'b0, 4'b0010, 2'd1, 1, 0); // busy 2
        add(4'b0010, 1'b0, 4'b0010, 2'd1, 1, 0); // busy 3 -> forced release
        add(4'b0000, 1'b0, 4'b0000, 2'd1, 0, 1); // timeout pulse
        add(4'b0000, 1'b0, 4'b0000, 2'd1, 0, 0); // pulse is one cycle
        add(4'b1000, 1'b0, 4'b0000, 2'd1, 0, 0); // ack on last cycle
        add(4'b1000, 1'b0, 4'b1000, 2'd3, 1, 0);
        add(4'b1000, 1'b0, 4'b1000, 2'd3, 1, 0);
        add(4'b1000, 1'b1, 4'b1000, 2'd3, 1, 0); // ack beats timeout
        add(4'b0000, 1'b0, 4'b0000, 2'd3, 0, 0); // no pulse
        add(4'b0100, 1'b0, 4'b0000, 2'd3, 0, 0); // abort case, ptr=0
        add(4'b0000, 1'b0, 4'b0100, 2'd2, 1, 0); // req2 dropped, no ack
        add(4'b1111, 1'b0, 4'b0000, 2'd2, 0, 0); // released, no pulse
        add(4'b1111, 1'b1, 4'b1000, 2'd3, 1, 0); // search started at 3
        add(4'b1111, 1'b0, 4'b0000, 2'd3, 0, 0); // rotation 0,1,2,3,0
        add(4'b1111, 1'b1, 4'b0001, 2'd0, 1, 0);
        add(4'b1111, 1'b0, 4'b0000, 2'd0, 0, 0);
        add(4'b1111, 1'b1, 4'b0010, 2'd1, 1, 0);
        add(4'b1111, 1'b0, 4'b0000, 2'd1, 0, 0);
        add(4'b1111, 1'b1, 4'b0100, 2'd2, 1, 0);
        add(4'b1111, 1'b0, 4'b0000, 2'd2, 0, 0);
        add(4'b1111, 1'b1, 4'b1000, 2'd3, 1, 0);
        add(4'b1111, 1'b0, 4'b0000, 2'd3, 0, 0);
        add(4'b1111, 1'b1, 4'b0001, 2'd0, 1, 0);
        add(4'b0000, 1'b0, 4'b0000, 2'd0, 0, 0);

        // Reset values.
        @(negedge clk);
        chk("rst.grant",     {28'd0, grant},     32'd0);
        chk("rst.gnt_id",    {30'd0, gnt_id},    32'd0);
        chk("rst.bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst.bus_data",  bus_data,           32'd0);
        chk("rst.timeout",   {31'd0, timeout},   32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            req = tbl[i].req;
            ack = tbl[i].ack;
            @(negedge clk);
            chk($sformatf("tbl%0d.grant", i),     {28'd0, grant},     {28'd0, tbl[i].grant});
            chk($sformatf("tbl%0d.gnt_id", i),    {30'd0, gnt_id},    {30'd0, tbl[i].id});
            chk($sformatf("tbl%0d.bus_valid", i), {31'd0, bus_valid}, {31'd0, tbl[i].valid});
            chk($sformatf("tbl%0d.bus_data", i),  bus_data,
                tbl[i].valid ? tdata[tbl[i].id] : 32'd0);
            chk($sformatf("tbl%0d.timeout", i),   {31'd0, timeout},   {31'd0, tbl[i].tmo});
            @(posedge clk); #1;
        end

        // Combinational bus_data follows a data change within the cycle.
        // ptr is 1 after the table, so req=1000 grants requester 3.
        req = 4'b1000; ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold.grant", {28'd0, grant}, 32'h8);
        data3 = 32'hDEADBEEF;
        #1;
        chk("comb.bus_data", bus_data, 32'hDEADBEEF);

        // Asynchronous reset in the middle of a BUSY cycle.
        #1;
        reset = 1'b1;
        #1;
        chk("async.grant",     {28'd0, grant},     32'd0);
        chk("async.bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("async.bus_data",  bus_data,           32'd0);
        chk("async.timeout",   {31'd0, timeout},   32'd0);
        chk("async.gnt_id",    {30'd0, gnt_id},    32'd0);
        @(posedge clk); #1;
        req = 4'b1001;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst.idle", {28'd0, grant}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst.grant",   {28'd0, grant},   32'h1);
        chk("post_rst.timeout", {31'd0, timeout}, 32'd0);

        // Randomised run against the reference model.
        @(posedge clk); #1;
        reset = 1'b1; req = 4'b0; ack = 1'b0;
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) reset = ($urandom_range(0, 199) == 0);
            if (reset) m_reset();
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            ack   = ($urandom_range(0, 4) == 0);
            data0 = $urandom; data1 = $urandom; data2 = $urandom; data3 = $urandom;
            m_data[0] = data0; m_data[1] = data1; m_data[2] = data2; m_data[3] = data3;
            @(negedge clk);
            m_compare($sformatf("rnd%0d", c));
            @(posedge clk);
            if (!reset) m_step(req, ack);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_word_bus_arbiter

// File: doc/word_bus_arbiter.md
WORD_BUS_ARBITER -- requirements
Module: word_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 15, max BUSY cycles without ack before forced release (legal 1..255).
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  4  per-requester bus request, level, held until granted transfer ends.
REQ-005 Port: data0, data1, data2, data3  input  32 each  per-requester write word.
REQ-006 Port: ack  input  1  shared-bus target completion, single-cycle pulse.
REQ-007 Port: grant  output  4  one-hot grant, registered.
REQ-008 Port: gnt_id  output  2  binary index of granted requester, registered.
REQ-009 Port: bus_valid  output  1  high while a grant is active.
REQ-010 Port: bus_data  output  32  shared bus word.
REQ-011 Port: timeout  output  1  one-cycle pulse on forced release.

Function
REQ-012 States SHALL be IDLE and BUSY only.
REQ-013 IDLE, any req bit set: next edge SHALL select first set bit searching upward from pointer ptr (mod 4), load grant/gnt_id, set bus_valid, clear counter, enter BUSY.
REQ-014 IDLE, req==0: SHALL stay IDLE, outputs unchanged at idle values.
REQ-015 Request-to-grant latency SHALL be exactly 1 cycle from IDLE.
REQ-016 BUSY: bus_data SHALL equal data[gnt_id] combinationally, same cycle as data changes.
REQ-017 bus_data SHALL be 32'h0 whenever bus_valid is 0.
REQ-018 BUSY, ack=1: next edge SHALL clear grant, bus_valid, return to IDLE, set ptr = gnt_id+1 mod 4.
REQ-019 BUSY, req[gnt_id]=0 and ack=0: abort; same release and ptr update as REQ-018, no timeout pulse.
REQ-020 BUSY counter SHALL increment each BUSY cycle without ack; on reaching TIMEOUT, next edge SHALL release as REQ-018 and pulse timeout for 1 cycle.
REQ-021 ack and timeout condition in same cycle: ack SHALL win, no timeout pulse.
REQ-022 ack and req drop in same cycle: treated as ack completion.
REQ-023 ack while IDLE SHALL be ignored.
REQ-024 After release, at least one IDLE cycle SHALL occur before next grant (no back-to-back grant).
REQ-025 grant SHALL never have more than one bit set; gnt_id SHALL hold last value in IDLE.
REQ-026 Round-robin: requester continuously requesting SHALL be granted within 4 transactions.

Reset
REQ-027 reset=1 SHALL asynchronously force: state IDLE, grant 0, gnt_id 0, ptr 0, counter 0, bus_valid 0, timeout 0, bus_data 0.
REQ-028 reset mid-BUSY SHALL drop grant immediately, no timeout pulse; after deassert first grant search starts at requester 0.

Structure
REQ-029 Shared package SHALL hold state encoding (IDLE=0, BUSY=1), NUM_REQ=4, WORD_W=32.
REQ-030 bus_data selection SHALL instantiate sub-module four_word_mux (sel=gnt_id), output gated by bus_valid.
REQ-031 Priority search and ptr SHALL be in this module; no other sub-modules.

Verification
REQ-032 Reset, req=4'b0101, data0=32'hAAAA0000: cycle 1 grant=0001, bus_valid=1, bus_data=32'hAAAA0000; ack -> next cycle grant=0, then grant=0100.
REQ-033 req=4'b1111 held, ack 1 cycle after each grant: grant sequence 0001,0010,0100,1000,0001 with one IDLE cycle between.
REQ-034 TIMEOUT=3, req=4'b0010, no ack: grant 0010 for 3 BUSY cycles, then grant=0, timeout=1 for exactly 1 cycle.
REQ-035 TIMEOUT=3, ack in 3rd BUSY cycle: release, timeout stays 0.
REQ-036 Grant to requester 2, drop req[2] with no ack: grant=0 next cycle, timeout=0, next grant search starts at 3.
REQ-037 Assert reset mid-BUSY with grant=1000: grant, bus_valid, bus_data go 0 without clock edge; after release req=4'b1001 grants 0001.
